// File: rtl/mips_pkg.sv
// Shared definitions for the instruction encoder: opcode constants,
// instruction kind encoding, FSM states and common widths.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001010;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_J    = 3'd4,
        KIND_JAL  = 3'd5,
        KIND_ADDI = 3'd6,
        KIND_SUBI = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding an encoded word together with its byte address.
// The caller never pushes when full nor pops when empty.
module enc_fifo2 import mips_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [31:0]       wr_addr,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic [31:0]       rd_addr,
    output logic [1:0]        count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WORD_W-1:0] data_reg;
            logic [31:0]       addr_reg;

            // Capture word and address when the write pointer selects this entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    addr_reg <= '0;
                end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= wr_data;
                    addr_reg <= wr_addr;
                end
            end
        end
    endgenerate

    // Occupancy follows the push/pop combination of this cycle
    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers and occupancy; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
            if (rd_en) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

    assign rd_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign rd_addr = rd_ptr_reg ? g_entry[1].addr_reg : g_entry[0].addr_reg;
    assign count   = count_reg;

endmodule

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: accepts field-level requests, emits
// 32-bit words paired with byte addresses through a 2-entry FIFO.
// Optional feature: define INSTR_ENC_SUBI_EN to encode kind 7 (subi);
// otherwise kind 7 is rejected and raises the sticky err flag.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        done,
    output logic        err
);
    import mips_pkg::*;

    state_e      state_reg;
    state_e      state_next;
    logic [31:0] addr_reg;
    logic [31:0] addr_next;
    logic [31:0] addr_base;
    logic        err_reg;
    logic        err_next;
    logic        done_reg;
    logic        done_next;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        start_ok;
    logic [1:0]  fifo_count;

    // Translate the request fields into a machine word
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (kind_e'(in_kind))
            KIND_R:    enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
            KIND_LW:   enc_word = {OP_LW,   in_rs, in_rt, in_imm};
            KIND_SW:   enc_word = {OP_SW,   in_rs, in_rt, in_imm};
            KIND_BEQ:  enc_word = {OP_BEQ,  in_rs, in_rt, in_imm};
            KIND_J:    enc_word = {OP_J,   in_target};
            KIND_JAL:  enc_word = {OP_JAL, in_target};
            KIND_ADDI: enc_word = {OP_ADDI, in_rs, in_rt, in_imm};
            KIND_SUBI: begin
                enc_word = {OP_SUBI, in_rs, in_rt, in_imm};
`ifdef INSTR_ENC_SUBI_EN
                enc_ok   = 1'b1;
`else
                enc_ok   = 1'b0;
`endif
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Handshakes; in_ready uses the registered count so a pop while full
    // never opens a same-cycle push
    assign in_ready  = (fifo_count < 2'd2) && ((state_reg == ST_IDLE) || (state_reg == ST_RUN));
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_ok;
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    // Address of the next pushed word; start rebases it to zero first
    always_comb begin
        addr_base = start_ok ? 32'd0 : addr_reg;
        addr_next = push ? (addr_base + ADDR_STEP) : addr_base;
    end

    // Program sequencing, done pulse and sticky error
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = in_last ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (accept && in_last) state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_count == 2'd0) state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        done_next = (state_reg == ST_DRAIN) && (state_next == ST_DONE);
        err_next  = err_reg || (accept && !enc_ok);
    end

    // State, address, done and err registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= 32'd0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    enc_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (enc_word),
        .wr_addr (addr_base),
        .rd_en   (pop),
        .rd_data (out_instr),
        .rd_addr (out_addr),
        .count   (fifo_count)
    );

    assign done = done_reg;
    assign err  = err_reg;

endmodule
